// File: rtl/shiftreg_stim_checker_pkg.sv
// Shared types and constants for the shift-register stimulus/check stage.
// Provides the run-sequencing state enum and the saturating error-count helper.
package shiftreg_stim_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/shiftreg_bit_pacer.sv
// Bit-rate divider: emits a one-cycle tick every DIV enabled cycles.
// A synchronous clear restarts the count so the first tick lands DIV cycles after entry.
module shiftreg_bit_pacer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/shiftreg_stim_checker.sv
// Stimulus/check stage: serialises parallel words LSB-first into a shift chain and
// compares the chain tail against an internal mirror of what was shifted in.
module shiftreg_stim_checker
  import shiftreg_stim_checker_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHAIN_LEN = 32,
  parameter int DIV       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cfg_words,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             sr_din,
  output logic             sr_shift,
  input  logic             sr_q,
  output logic             busy,
  output logic             done,
  output logic [7:0]       err_cnt
);

  localparam int MAXB  = (CHAIN_LEN > WIDTH) ? CHAIN_LEN : WIDTH;
  localparam int CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;

  state_t               state, state_d;
  logic                 tick;
  logic                 flush_last, shift_last;
  logic [CNT_W-1:0]     bit_cnt;
  logic [7:0]           words_left;
  logic [WIDTH-1:0]     word_sr;
  logic [CHAIN_LEN-1:0] mirror, mirror_next;
  logic                 expected;

  assign expected   = mirror[CHAIN_LEN-1];
  assign flush_last = tick && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign shift_last = tick && (bit_cnt == CNT_W'(WIDTH - 1));
  assign sr_shift   = tick;

  if (CHAIN_LEN > 1) begin : g_mirror_wide
    assign mirror_next = {mirror[CHAIN_LEN-2:0], sr_din};
  end else begin : g_mirror_one
    assign mirror_next = sr_din;
  end

  shiftreg_bit_pacer #(
    .DIV(DIV)
  ) u_pacer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_d != state),
    .enable((state == FLUSH) || (state == SHIFT)),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    word_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_last) state_d = (words_left == '0) ? DONE : LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (shift_last) state_d = (words_left == '0) ? DONE : LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // word_sr holds the not-yet-sent bits; sr_din is preloaded so it is valid for the whole pulse cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      words_left <= '0;
      word_sr    <= '0;
      mirror     <= '0;
      sr_din     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            words_left <= cfg_words;
            err_cnt    <= '0;
            mirror     <= '0;
            bit_cnt    <= '0;
            sr_din     <= 1'b0;
          end
        end
        FLUSH: begin
          if (tick) begin
            mirror  <= mirror_next;
            bit_cnt <= flush_last ? '0 : bit_cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          if (word_valid) begin
            sr_din     <= word_in[0];
            word_sr    <= word_in >> 1;
            words_left <= words_left - 8'd1;
          end
        end
        SHIFT: begin
          if (tick) begin
            mirror  <= mirror_next;
            sr_din  <= word_sr[0];
            word_sr <= word_sr >> 1;
            bit_cnt <= shift_last ? '0 : bit_cnt + CNT_W'(1);
            if (sr_q != expected) err_cnt <= sat_inc(err_cnt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_stim_checker.sv
// Directed bench for shiftreg_stim_checker with a behavioural 32-bit chain model
// (ideal, inverted tail, or stuck-at-1 tail).
module tb_shiftreg_stim_checker;

  localparam int LIMIT = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_words = '0;
  logic [7:0] word_in = '0;
  logic       word_valid = 1'b0;
  logic       word_ready, sr_din, sr_shift, sr_q, busy, done;
  logic [7:0] err_cnt;

  int n_pass = 0;
  int n_total = 0;

  int          mode = 0;
  logic [31:0] chain = '0;
  int          tot_pulses = 0;
  int          done_total = 0;
  logic [31:0] stream = '0;

  always #5 clk = ~clk;

  shiftreg_stim_checker #(
    .WIDTH(8),
    .CHAIN_LEN(32),
    .DIV(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_words (cfg_words),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .sr_din    (sr_din),
    .sr_shift  (sr_shift),
    .sr_q      (sr_q),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt)
  );

  // chain under test
  always @(posedge clk) if (sr_shift) chain <= {chain[30:0], sr_din};
  assign sr_q = (mode == 2) ? 1'b1 : (mode == 1) ? ~chain[31] : chain[31];

  always @(negedge clk) begin
    if (sr_shift) begin
      tot_pulses <= tot_pulses + 1;
      stream     <= {sr_din, stream[31:1]};
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_run(input int n, input logic [31:0] ws, input int stall, input int poke,
                        output int pulses, output int dones, output int bad);
    int p0, d0, k, cyc;
    bit fin;
    p0 = tot_pulses; d0 = done_total;
    k = 0; cyc = 0; fin = 0; bad = 0;
    @(negedge clk); start = 1'b1; cfg_words = n[7:0];
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < LIMIT) begin
      start = (poke != 0 && cyc == 20);
      cfg_words = start ? 8'd9 : n[7:0];
      if (done) begin
        fin = 1;
      end else if (word_ready && k < n) begin
        for (int s = 0; s < stall && k == 0; s++) begin
          if (sr_shift !== 1'b0 || word_ready !== 1'b1) bad++;
          @(negedge clk); cyc++;
        end
        word_valid = 1'b1;
        word_in = (k < 4) ? ws[8*k +: 8] : 8'h00;
        @(negedge clk); cyc++;
        word_valid = 1'b0;
        k++;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check("run_complete", int'(fin), 1);
    start = (poke != 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
    pulses = tot_pulses - p0;
    dones  = done_total - d0;
  endtask

  typedef struct {
    int          n;
    logic [31:0] ws;
    int          mode;
    int          exp_pulses;
    int          exp_err;
    logic [31:0] exp_stream;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int pulses, dones, bad, p0, p1, d0, cyc;

    vecs[0] = '{4, 32'h00FF3CA5, 0, 64, 0,  32'h00FF3CA5};
    vecs[1] = '{2, 32'h00003412, 1, 48, 16, 32'h34120000};
    vecs[2] = '{0, 32'h00000000, 0, 32, 0,  32'h00000000};
    vecs[3] = '{1, 32'h00000081, 2, 40, 8,  32'h81000000};
    vecs[4] = '{3, 32'h007E8001, 0, 56, 0,  32'h7E800100};

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", int'({word_ready, sr_din, sr_shift, busy, done, err_cnt}), 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_outputs", int'({word_ready, sr_din, sr_shift, busy, done, err_cnt}), 0);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      do_run(vecs[i].n, vecs[i].ws, 0, 0, pulses, dones, bad);
      check($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
      check($sformatf("v%0d_err_cnt", i), int'(err_cnt), vecs[i].exp_err);
      check($sformatf("v%0d_stream", i), int'(stream), int'(vecs[i].exp_stream));
      check($sformatf("v%0d_done_pulses", i), dones, 1);
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // LOAD stall: valid held low for 10 cycles
    mode = 0;
    do_run(1, 32'h0000005A, 10, 0, pulses, dones, bad);
    check("stall_bad_cycles", bad, 0);
    check("stall_pulses", pulses, 40);
    check("stall_err_cnt", int'(err_cnt), 0);
    check("stall_stream", int'(stream), int'(32'h5A000000));

    // start pulsed mid-flush and during DONE
    mode = 1;
    do_run(2, 32'h00000FC3, 0, 1, pulses, dones, bad);
    check("poke_pulses", pulses, 48);
    check("poke_err_cnt", int'(err_cnt), 16);
    check("poke_done_pulses", dones, 1);
    repeat (5) @(negedge clk);
    #1;
    check("poke_busy_after", int'(busy), 0);
    check("poke_err_held", int'(err_cnt), 16);

    // stuck-at-1 tail over 304 data bits of zeros: saturates
    mode = 2;
    do_run(38, 32'h00000000, 0, 0, pulses, dones, bad);
    check("stuck_pulses", pulses, 336);
    check("stuck_err_sat", int'(err_cnt), 255);
    check("stuck_done_pulses", dones, 1);

    // reset mid-SHIFT
    mode = 0;
    @(negedge clk); start = 1'b1; cfg_words = 8'd1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!word_ready && cyc < LIMIT) begin @(negedge clk); cyc++; end
    check("rst_reach_load", int'(word_ready), 1);
    word_valid = 1'b1; word_in = 8'hF0;
    @(negedge clk); word_valid = 1'b0;
    #1;
    p0 = tot_pulses; cyc = 0;
    while (tot_pulses < p0 + 3 && cyc < LIMIT) begin @(negedge clk); #1; cyc++; end
    check("rst_mid_shift_busy", int'(busy), 1);
    d0 = done_total;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_outputs", int'({word_ready, sr_din, sr_shift, busy, done, err_cnt}), 0);
    p1 = tot_pulses;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("rst_no_done", done_total - d0, 0);
    check("rst_no_pulses", tot_pulses - p1, 0);
    check("rst_idle_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
